req_onehot_arbiter: RTL and testbench
=====================================

// Module: req_onehot_arbiter
// PURPOSE
//  Upstream stage of the 4-to-2 encoder. Captures rising edges on 4 raw request lines,
//  buffers them in per-channel pending counters, and issues one request at a time as a
//  one-hot 4-bit word (feeds encoder 'data') under a valid/ready handshake.
//  Grant order is round-robin, so downstream never sees multi-hot or ambiguous codes.
// PARAMETERS
//  CNT_W        3  width of each per-channel pending-event counter (saturates at 2^CNT_W-1)
//  SYNC_STAGES  2  flop stages per request line when ARB_SYNC_EN is defined (>=2)
// PORTS
//  clk          in   1  single clock, all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  req_in       in   4  raw request lines, one per channel
//  data_out     out  4  one-hot grant word to encoder; 4'b0000 when data_valid=0
//  data_valid   out  1  data_out holds a grant
//  data_ready   in   1  downstream accepts data_out on a cycle with valid&ready
//  overflow     out  4  sticky per-channel flag: an edge arrived while counter saturated
//  pending_any  out  1  OR of (pend_cnt[i]!=0), registered-state based
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): data_out=0, data_valid=0, overflow=0, pend_cnt[*]=0,
//    rr pointer=3 (channel 0 has first priority), req_prev <= current (synced) req_in,
//    so lines already high on reset release generate no event. Applies mid-operation:
//    all pending events and any held grant are discarded.
//  - Edge detect: rise[i] = req_s[i] & ~req_prev[i]; req_prev <= req_s every cycle.
//    req_s = req_in directly, or synchronizer output if ARB_SYNC_EN.
//  - Pending counter i, per edge: +1 on rise[i], -1 when channel i is loaded into output,
//    both same cycle -> unchanged. At max value a rise without a load -> stays at max,
//    overflow[i] <= 1 (clears only on rst).
//  - Output register load condition: load_ok = ~data_valid | data_ready.
//    If load_ok and any pend_cnt!=0: pick first i with pend_cnt[i]!=0 searching
//    rr+1, rr+2, rr+3, rr (mod 4); data_out <= 1<<i, data_valid <= 1, rr <= i, pend_cnt[i]-1.
//    If load_ok and none pending: data_out <= 0, data_valid <= 0.
//    If ~load_ok: data_out/data_valid hold (stable under backpressure).
//  - Selection uses registered pend_cnt (pre-edge values); a rise counted at edge k is
//    grantable at edge k+1 at earliest.
//  - Latency (no sync): req_in rises, first sampled high at edge k -> pend_cnt=1 after k ->
//    data_out one-hot, data_valid=1 after edge k+1. Back-to-back grants 1/cycle with ready=1.
//  - data_out is never multi-hot; data_valid=1 implies exactly one bit set.
// CONFIGURATION
//  ARB_SYNC_EN defined: each req_in bit passes SYNC_STAGES flops (reset to 0... then
//    req_prev follows rule above) before edge detect; latency grows by SYNC_STAGES cycles.
//  ARB_SYNC_EN undefined: req_in assumed synchronous to clk, used directly; no sync flops.
// TESTING
//  1 Reset: rst=1 2 cycles, req_in=4'b1111 -> after release data_valid=0, data_out=0,
//    overflow=0, no grants while lines stay high.
//  2 Single: ready=1, pulse req_in=4'b0100 1 cycle -> data_out=4'b0100, valid=1 exactly
//    1 cycle, 2 edges after first sample (no sync); then valid=0.
//  3 Round-robin: ready=1, pulse req_in=4'b1111 once -> grants 0001,0010,0100,1000 on
//    consecutive cycles; pulse 4'b1001 next -> order 0001 then 1000 (rr continues from 3).
//  4 Backpressure: ready=0, pulses on ch1,ch2 -> data_out=4'b0010 held stable, valid=1;
//    raise ready -> 0010 accepted, next cycle 0100, then valid=0.
//  5 Saturation: ready=0, 9 pulses on ch3 (CNT_W=3) -> overflow=4'b1000; ready=1 ->
//    exactly 8 grants of 4'b1000 total (1 held + 7 pending), overflow stays 1.
//  6 Mid-op reset: 3 pending on ch0, assert rst 1 cycle -> no further grants, pending_any=0;
//    simultaneous rise+load on ch2 leaves pend_cnt[2] unchanged (check via grant count).

Source files
------------

// File: rtl/req_onehot_arbiter.sv
// Round-robin one-hot request arbiter: rising-edge capture, per-channel pending counters,
// valid/ready output register. Optional input synchronizer enabled by `define ARB_SYNC_EN.
module req_onehot_arbiter #(
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    output logic [3:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [3:0] overflow,
    output logic       pending_any
);

    localparam int unsigned NCH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH-1:0]   req_s;
    logic [NCH-1:0]   req_prev;
    logic [NCH-1:0]   rise;
    logic [CNT_W-1:0] pend_cnt [NCH];
    logic [CNT_W-1:0] pend_nxt [NCH];
    logic [1:0]       rr;
    logic [1:0]       rr_nxt;
    logic [1:0]       sel;
    logic [1:0]       idx;
    logic             found;
    logic             load_ok;
    logic             grant;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   ovf_nxt;
    logic [NCH-1:0]   data_nxt;
    logic             valid_nxt;
    logic             any_nxt;

`ifdef ARB_SYNC_EN
    logic [NCH-1:0] sync_q [SYNC_STAGES];

    // Multi-flop synchronizer per request line
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
`else
    assign req_s = req_in;
`endif

    // Edge detect, round-robin pick and next-state for counters and output register
    always_comb begin
        load_ok   = ~data_valid | data_ready;
        rise      = req_s & ~req_prev;
        found     = 1'b0;
        sel       = '0;
        idx       = '0;
        load      = '0;
        ovf_nxt   = overflow;
        data_nxt  = data_out;
        valid_nxt = data_valid;
        rr_nxt    = rr;
        any_nxt   = 1'b0;

        // Search order rr+1, rr+2, rr+3, rr so the last winner has lowest priority
        for (int k = 1; k <= int'(NCH); k++) begin
            idx = rr + 2'(k);
            if (!found && (pend_cnt[idx] != '0)) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        grant = load_ok & found;

        for (int i = 0; i < int'(NCH); i++) begin
            load[i]     = grant && (sel == 2'(i));
            pend_nxt[i] = pend_cnt[i];
            if (rise[i] && !load[i]) begin
                if (pend_cnt[i] == CNT_MAX) ovf_nxt[i] = 1'b1;
                else                        pend_nxt[i] = pend_cnt[i] + CNT_W'(1);
            end else if (!rise[i] && load[i]) begin
                pend_nxt[i] = pend_cnt[i] - CNT_W'(1);
            end
            any_nxt = any_nxt | (pend_nxt[i] != '0);
        end

        if (load_ok) begin
            if (found) begin
                data_nxt  = 4'b0001 << sel;
                valid_nxt = 1'b1;
                rr_nxt    = sel;
            end else begin
                data_nxt  = '0;
                valid_nxt = 1'b0;
            end
        end
    end

    // State registers; reset samples req_s so lines already high create no event
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            overflow    <= '0;
            pending_any <= 1'b0;
            rr          <= 2'd3;
            req_prev    <= req_s;
            for (int i = 0; i < int'(NCH); i++) pend_cnt[i] <= '0;
        end else begin
            data_out    <= data_nxt;
            data_valid  <= valid_nxt;
            overflow    <= ovf_nxt;
            pending_any <= any_nxt;
            rr          <= rr_nxt;
            req_prev    <= req_s;
            for (int i = 0; i < int'(NCH); i++) pend_cnt[i] <= pend_nxt[i];
        end
    end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Bench for req_onehot_arbiter: per-cycle vector table plus scoreboarded grant sequences.
module tb_req_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [3:0] overflow;
    logic       pending_any;

    int errors = 0;
    int checks = 0;
    logic sb_en = 1'b0;
    logic [3:0] exp_q [$];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ready;
        logic       ev;
        logic [3:0] ed;
        logic [3:0] eo;
        logic       ep;
    } vec_t;

    vec_t vecs [$];

    req_onehot_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow),
        .pending_any(pending_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic rdy,
                       input logic ev, input logic [3:0] ed, input logic [3:0] eo, input logic ep);
        vec_t v;
        v.rst = r; v.req = q; v.ready = rdy; v.ev = ev; v.ed = ed; v.eo = eo; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic tick(input logic r, input logic [3:0] q, input logic rdy);
        rst = r; req_in = q; data_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted grant must match the next expected word
    always @(negedge clk) begin
        if (sb_en && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got %b, required no grant at %0t", data_out, $time);
            end else begin
                chk("grant", int'(data_out), int'(exp_q.pop_front()));
                chk("onehot", $countones(data_out), 1);
            end
        end
    end

    initial begin
        rst = 1'b1; req_in = 4'b1111; data_ready = 1'b1;

        // Reset with all lines high, then release: no events
        add(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0);
        add(1, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        // Single pulse on ch2: grant two edges after first sample, valid for one cycle
        add(0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b0100, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        // Round robin from fresh reset, then 1001 continues after rr=3
        add(1, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b0001, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b0010, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b0100, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b1000, 4'b0000, 0);
        add(0, 4'b1001, 1, 0, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b0001, 4'b0000, 1);
        add(0, 4'b0000, 1, 1, 4'b1000, 4'b0000, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);

        foreach (vecs[n]) begin
            tick(vecs[n].rst, vecs[n].req, vecs[n].ready);
            chk($sformatf("vec%0d_valid", n), int'(data_valid), int'(vecs[n].ev));
            chk($sformatf("vec%0d_data", n), int'(data_out), int'(vecs[n].ed));
            chk($sformatf("vec%0d_ovf", n), int'(overflow), int'(vecs[n].eo));
            chk($sformatf("vec%0d_pany", n), int'(pending_any), int'(vecs[n].ep));
        end

        sb_en = 1'b1;

        // Backpressure: ch1 held stable, then ch2 follows once ready rises
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        tick(0, 4'b0010, 0);
        tick(0, 4'b0100, 0);
        for (int c = 0; c < 3; c++) begin
            tick(0, 4'b0000, 0);
            chk("bp_hold_data", int'(data_out), 4'b0010);
            chk("bp_hold_valid", int'(data_valid), 1);
        end
        for (int c = 0; c < 4; c++) tick(0, 4'b0000, 1);
        chk("bp_valid_low", int'(data_valid), 0);
        chk("bp_sb_empty", exp_q.size(), 0);

        // Saturation: 9 pulses on ch3 under backpressure -> 1 held + 7 pending
        for (int c = 0; c < 8; c++) exp_q.push_back(4'b1000);
        for (int c = 0; c < 9; c++) begin
            tick(0, 4'b1000, 0);
            tick(0, 4'b0000, 0);
        end
        chk("sat_ovf", int'(overflow), 4'b1000);
        chk("sat_held", int'(data_out), 4'b1000);
        for (int c = 0; c < 12; c++) tick(0, 4'b0000, 1);
        chk("sat_sb_empty", exp_q.size(), 0);
        chk("sat_ovf_sticky", int'(overflow), 4'b1000);
        chk("sat_valid_low", int'(data_valid), 0);

        // Mid-operation reset discards held grant and pending events
        for (int c = 0; c < 4; c++) begin
            tick(0, 4'b0001, 0);
            tick(0, 4'b0000, 0);
        end
        chk("mr_pany_before", int'(pending_any), 1);
        chk("mr_held", int'(data_out), 4'b0001);
        tick(1, 4'b0000, 0);
        chk("mr_valid", int'(data_valid), 0);
        chk("mr_data", int'(data_out), 0);
        chk("mr_pany", int'(pending_any), 0);
        chk("mr_ovf", int'(overflow), 0);
        for (int c = 0; c < 6; c++) tick(0, 4'b0000, 1);
        chk("mr_no_grant", int'(data_valid), 0);

        // Simultaneous rise and load on ch2 keeps its counter unchanged
        for (int c = 0; c < 3; c++) exp_q.push_back(4'b0100);
        tick(0, 4'b0100, 0);
        tick(0, 4'b0000, 0);
        tick(0, 4'b0100, 0);
        tick(0, 4'b0000, 0);
        tick(0, 4'b0100, 1);
        for (int c = 0; c < 5; c++) tick(0, 4'b0000, 1);
        chk("sim_sb_empty", exp_q.size(), 0);
        chk("sim_valid_low", int'(data_valid), 0);
        chk("sim_pany", int'(pending_any), 0);

        sb_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
